// File: rtl/ball_motion_ctrl.sv
// Ball motion controller: owns ball position/direction, steps once per game tick, bounces via collision checker.
// Latency: first step TICK_DIV cycles after serve, then 1 STEP cycle; x/y/dir registered, update on STEP->REQ edge.
// Backpressure: holds in REQ with chk_req=1 and x/y frozen until chk_ack; pause freezes ticking/stepping. Optional macro: BALL_LOST_EN.
module ball_motion_ctrl #(
  parameter logic [9:0]  X_START   = 10'd80,
  parameter logic [9:0]  Y_START   = 10'd60,
  parameter logic [1:0]  DIR_START = 2'b00,
  parameter logic [19:0] TICK_DIV  = 20'd833333,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             pause,
  output logic             chk_req,
  input  logic             chk_ack,
  input  logic [1:0]       chk_code,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic [1:0]       dir,
  output logic             moving,
  output logic [CNT_W-1:0] bounce_cnt,
  output logic             lost
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_STEP,
`ifdef BALL_LOST_EN
    S_LOST,
`endif
    S_REQ
  } state_t;

  state_t            state, state_nxt;
  logic [19:0]       tick_cnt, tick_cnt_nxt;
  logic [9:0]        x_nxt, y_nxt;
  logic [1:0]        dir_nxt;
  logic [CNT_W-1:0]  bounce_nxt, bounce_inc;
  // Set when the last step bounced off a zero edge, so a checker hit in the
  // same step does not count a second bounce.
  logic              guard_hit, guard_hit_nxt;
  logic              gx, gy;
`ifdef BALL_LOST_EN
  logic              lost_q, lost_nxt;
`endif

  assign bounce_inc = (&bounce_cnt) ? bounce_cnt : bounce_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and next datapath values; defaults hold everything
  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    x_nxt         = x;
    y_nxt         = y;
    dir_nxt       = dir;
    bounce_nxt    = bounce_cnt;
    guard_hit_nxt = guard_hit;
    gx            = 1'b0;
    gy            = 1'b0;
`ifdef BALL_LOST_EN
    lost_nxt      = lost_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_WAIT_TICK;
          tick_cnt_nxt = '0;
          bounce_nxt   = '0;
        end
      end
      S_WAIT_TICK: begin
        if (!pause) begin
          if (tick_cnt == TICK_DIV - 20'd1) begin
            tick_cnt_nxt = '0;
            state_nxt    = S_STEP;
          end else begin
            tick_cnt_nxt = tick_cnt + 20'd1;
          end
        end
      end
      S_STEP: begin
        // Pause also holds the step itself so the position stays frozen.
        if (!pause) begin
`ifdef BALL_LOST_EN
          if (y == 10'd0 && dir[1]) begin
            state_nxt = S_LOST;
            lost_nxt  = 1'b1;
          end else
`endif
          begin
            // Zero edges never wrap: hold the coordinate and reflect instead.
            gx = (x == 10'd0) && dir[0];
            gy = (y == 10'd0) && dir[1];
            if (gx)          dir_nxt[0] = 1'b0;
            else if (dir[0]) x_nxt = x - 10'd1;
            else             x_nxt = x + 10'd1;
            if (gy)          dir_nxt[1] = 1'b0;
            else if (dir[1]) y_nxt = y - 10'd1;
            else             y_nxt = y + 10'd1;
            guard_hit_nxt = gx | gy;
            if (gx | gy) bounce_nxt = bounce_inc;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (chk_ack) begin
          if (chk_code[1]) begin
            if (chk_code[0]) dir_nxt[1] = ~dir[1];
            else             dir_nxt[0] = ~dir[0];
            if (!guard_hit) bounce_nxt = bounce_inc;
          end
          state_nxt = S_WAIT_TICK;
        end
      end
`ifdef BALL_LOST_EN
      S_LOST: begin
        if (start) begin
          x_nxt        = X_START;
          y_nxt        = Y_START;
          dir_nxt      = DIR_START;
          lost_nxt     = 1'b0;
          tick_cnt_nxt = '0;
          bounce_nxt   = '0;
          state_nxt    = S_WAIT_TICK;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_cnt   <= '0;
      x          <= X_START;
      y          <= Y_START;
      dir        <= DIR_START;
      bounce_cnt <= '0;
      guard_hit  <= 1'b0;
      chk_req    <= 1'b0;
      moving     <= 1'b0;
    end else begin
      tick_cnt   <= tick_cnt_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      dir        <= dir_nxt;
      bounce_cnt <= bounce_nxt;
      guard_hit  <= guard_hit_nxt;
      chk_req    <= (state_nxt == S_REQ);
`ifdef BALL_LOST_EN
      moving     <= (state_nxt != S_IDLE) && (state_nxt != S_LOST);
`else
      moving     <= (state_nxt != S_IDLE);
`endif
    end
  end

`ifdef BALL_LOST_EN
  // Ball-lost flag register
  always_ff @(posedge clk) begin
    if (!resetn) lost_q <= 1'b0;
    else         lost_q <= lost_nxt;
  end
  assign lost = lost_q;
`else
  assign lost = 1'b0;
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Testbench for ball_motion_ctrl: random checker codes, ack delays, pause and stray start pulses.
// Expected step results come from a transaction-level model pushed at each serve/ack.
// A monitor pops on each chk_req rise and checks timing, position, direction and bounce count.
module tb_ball_motion_ctrl;
  localparam int          TD = 4;
  localparam logic [9:0]  XS = 10'd3;
  localparam logic [9:0]  YS = 10'd2;
  localparam logic [1:0]  DS = 2'b11;
  localparam int          CW = 3;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          chk_ack = 1'b0;
  logic [1:0]    chk_code = 2'b00;
  logic          chk_req;
  logic [9:0]    x, y;
  logic [1:0]    dir;
  logic          moving;
  logic [CW-1:0] bounce_cnt;
  logic          lost;

  ball_motion_ctrl #(
    .X_START(XS), .Y_START(YS), .DIR_START(DS), .TICK_DIV(20'(TD)), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause),
    .chk_req(chk_req), .chk_ack(chk_ack), .chk_code(chk_code),
    .x(x), .y(y), .dir(dir), .moving(moving), .bounce_cnt(bounce_cnt), .lost(lost)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ball state as plain integers, advanced one step at a time
  typedef struct {
    int         x;
    int         y;
    logic [1:0] dir;
    int         cnt;
  } exp_t;
  exp_t       q[$];
  int         mx, my, mcnt;
  logic [1:0] mdir;
  bit         mguard;

  task automatic model_step();
    bit g;
    logic [1:0] d;
    g = 0;
    d = mdir;
    if (d[0] == 1'b0)  mx = mx + 1;
    else if (mx == 0) begin mdir[0] = 1'b0; g = 1; end
    else               mx = mx - 1;
    if (d[1] == 1'b0)  my = my + 1;
    else if (my == 0) begin mdir[1] = 1'b0; g = 1; end
    else               my = my - 1;
    if (g && mcnt < CMAX) mcnt = mcnt + 1;
    mguard = g;
    q.push_back('{x: mx, y: my, dir: mdir, cnt: mcnt});
  endtask

  task automatic model_ack(input logic [1:0] code);
    if (code[1]) begin
      if (code[0]) mdir[1] = ~mdir[1];
      else         mdir[0] = ~mdir[0];
      if (!mguard && mcnt < CMAX) mcnt = mcnt + 1;
    end
  endtask

  // Monitor: timing of each step, scoreboard pop, and REQ stability
  bit         mon_en = 0;
  bit         waiting = 0;
  int         unp = 0;
  logic [9:0] hx = '0, hy = '0;
  logic [1:0] hd = '0;
  bit         run_pause = 0;

  always @(posedge clk) begin
    bit p, a, r0, st, mv0;
    exp_t e;
    p = pause; a = chk_ack; r0 = chk_req; st = start; mv0 = moving;
    #1;
    if (mon_en) begin
      if (r0) begin
        if (a) chk("req_drop_after_ack", int'(chk_req), 0);
        else begin
          chk("req_held", int'(chk_req), 1);
          chk("x_stable", int'(x), int'(hx));
          chk("y_stable", int'(y), int'(hy));
          chk("dir_stable", int'(dir), int'(hd));
        end
      end
      if ((r0 && a) || (st && !mv0 && !r0)) begin
        waiting = 1;
        unp = 0;
      end else if (waiting) begin
        if (!p) unp++;
        if (unp == TD + 1 || chk_req) begin
          chk("req_rise_cycle", unp, TD + 1);
          chk("req_rise", int'(chk_req), 1);
          chk("moving_in_req", int'(moving), 1);
          if (q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
          end else begin
            e = q.pop_front();
            chk("step_x", int'(x), e.x);
            chk("step_y", int'(y), e.y);
            chk("step_dir", int'(dir), int'(e.dir));
            chk("bounce_cnt", int'(bounce_cnt), e.cnt);
          end
          hx = x; hy = y; hd = dir;
          waiting = 0;
        end
      end
    end
  end

  // Random pause, active only during the randomized run
  initial begin
    forever begin
      @(negedge clk);
      pause = run_pause ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (chk_req) begin ok = 1; break; end
    end
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    logic [1:0] code;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_chk_req", int'(chk_req), 0);
    chk("rst_x", int'(x), int'(XS));
    chk("rst_y", int'(y), int'(YS));
    chk("rst_dir", int'(dir), int'(DS));
    chk("rst_moving", int'(moving), 0);
    chk("rst_bounce", int'(bounce_cnt), 0);
    chk("rst_lost", int'(lost), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_x", int'(x), int'(XS));
    chk("idle_moving", int'(moving), 0);
    chk("idle_req", int'(chk_req), 0);

    // Serve
    mon_en = 1;
    mx = int'(XS); my = int'(YS); mdir = DS; mcnt = 0; mguard = 0;
    model_step();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_pause = 1;

    for (int t = 0; t < 80; t++) begin
      wait_req(ok);
      if (!ok) break;
      repeat ($urandom_range(0, 7)) @(negedge clk);
      code = 2'($urandom_range(0, 3));
      chk_ack = 1'b1;
      chk_code = code;
      model_ack(code);
      model_step();
      @(negedge clk);
      chk_ack = 1'b0;
      chk_code = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    // Reset in the middle of a handshake
    wait_req(ok);
    mon_en = 0;
    run_pause = 0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("midreq_rst_chk_req", int'(chk_req), 0);
    chk("midreq_rst_x", int'(x), int'(XS));
    chk("midreq_rst_y", int'(y), int'(YS));
    chk("midreq_rst_dir", int'(dir), int'(DS));
    chk("midreq_rst_moving", int'(moving), 0);
    chk("midreq_rst_bounce", int'(bounce_cnt), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (TD + 4) @(negedge clk);
    chk("post_rst_idle_req", int'(chk_req), 0);
    chk("post_rst_idle_x", int'(x), int'(XS));
    chk("post_rst_idle_moving", int'(moving), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Owns the ball's position and direction register and steps the ball once per game tick.
- Sits on the opposite side of the collision interface from the collision checker:
  - presents the new position with a request;
  - consumes the returned 2-bit collision code;
  - applies the bounce to the direction.
- Feeds x/y to the VGA draw path.

Parameters:
- X_START, 10'd80, ball X after reset/serve
- Y_START, 10'd60, ball Y after reset/serve
- DIR_START, 2'b00, direction after reset/serve (00 up-right, 01 up-left, 10 down-right, 11 down-left)
- TICK_DIV, 20'd833333, clk cycles per motion step (min 2)
- CNT_W, 8, width of bounce counter

Ports:
- clk  in  1  system clock, all logic on posedge
- resetn  in  1  synchronous active-low reset; sampled on posedge clk
- start  in  1  serve pulse; begins motion from IDLE
- pause  in  1  freezes tick counter and position while high
- chk_req  out  1  collision-check request; x/y stable while high
- chk_ack  in  1  collision result valid, sampled only while chk_req=1
- chk_code  in  2  {hit, axis}: 0x none, 10 X collision, 11 Y collision
- x  out  10  ball X
- y  out  10  ball Y
- dir  out  2  current direction
- moving  out  1  high in any state except IDLE (and LOST)
- bounce_cnt  out  CNT_W  bounces applied since serve, saturating
- lost  out  1  ball-lost flag (BALL_LOST_EN only; tied 0 otherwise)

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE, x=X_START, y=Y_START, dir=DIR_START;
  - chk_req=0, bounce_cnt=0, lost=0, tick counter=0.
  - Reset overrides everything, including mid-handshake: chk_req drops the next cycle.
- States: IDLE, WAIT_TICK, STEP, REQ (LOST with macro).
- IDLE:
  - outputs hold start values;
  - start=1 -> WAIT_TICK, tick counter cleared, bounce_cnt cleared.
- WAIT_TICK:
  - counter increments each cycle unless pause=1 (holds);
  - at count==TICK_DIV-1 the counter wraps to 0 and the state goes to STEP;
  - the first step therefore occurs TICK_DIV cycles after start.
- STEP (1 cycle), using dir as it is on entry:
  - dir[0]=0 gives x+1, dir[0]=1 gives x-1;
  - dir[1]=0 gives y+1, dir[1]=1 gives y-1;
  - -> REQ.
- STEP edge guard:
  - if x==0 and dir[0]=1: x holds and dir[0] flips.
  - if y==0 and dir[1]=1: y holds and dir[1] flips.
  - A flip from the edge guard counts as a bounce.
  - No wrap-around ever occurs at 0; upper walls are the checker's responsibility.
- REQ:
  - chk_req=1; x/y/dir frozen;
  - stays in REQ until chk_ack=1, with no timeout;
  - pause has no effect in REQ.
- REQ on chk_ack=1 (same edge):
  - chk_code=10: dir[0] inverts;
  - chk_code=11: dir[1] inverts;
  - chk_code=0x: dir unchanged;
  - on any hit, bounce_cnt+1, saturating at all-ones;
  - -> WAIT_TICK; chk_req=0 the next cycle.
- start while not IDLE: ignored.
- Edge-guard flip and checker flip in the same step: both apply; bounce_cnt increments by 1 only.
- All outputs are registered. x/y change only on the STEP->REQ edge.

Optional Feature:
- Macro: BALL_LOST_EN.
- When defined:
  - in STEP, y==0 with dir[1]=1 means the ball passed the paddle; no edge-guard flip is applied;
  - -> LOST, lost=1, moving=0, chk_req=0, position held;
  - LOST exits only on start: reload X_START/Y_START/DIR_START, lost=0, -> WAIT_TICK.
- When undefined:
  - LOST state is not present and lost is tied 0;
  - the bottom edge uses the edge guard (bounce).

Test Plan:
- Reset then serve, TICK_DIV=4, start at cycle 0:
  - chk_req rises after 4 ticks+STEP;
  - x=81, y=61, dir=00; ack code 00 -> dir stays 00, bounce_cnt=0.
- X bounce: at x=81, y=61, dir=00, ack code 10 -> dir=01; next step x=80, y=62, bounce_cnt=1.
- Y bounce: dir=01, ack code 11 -> dir=11; next step x-1, y-1.
- Left-wall guard: X_START=0, DIR_START=01 -> first step x=0 (held), dir=00, y=Y_START+1, bounce_cnt=1.
- Pause/handshake: pause=1 for 10 cycles in WAIT_TICK -> step delayed exactly 10 cycles. With chk_ack withheld for 7 cycles in REQ:
  - chk_req stays 1;
  - x/y are stable;
  - no further steps occur.
- Reset mid-REQ: resetn=0 while chk_req=1 -> next cycle chk_req=0, x=X_START, state IDLE. With BALL_LOST_EN, y=0 and dir=11 at step -> lost=1, moving=0; start -> lost=0, position reloads.
